// File: rtl/gray_run_ctrl_pkg.sv
// Shared state encodings and default timing constants for the Gray counter run/pause/clear sequencer.
// Optional wrap-stop behaviour in the top is enabled with macro GRAY_WRAP_STOP_EN.
package gray_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE,
    S_CLEAR = ST_CLEAR
  } state_e;

  // 1 Hz enable and 2 s long press at a 100 MHz clock
  localparam int unsigned DEF_PERIOD   = 100_000_000;
  localparam int unsigned DEF_LONG_CYC = 200_000_000;

endpackage

// File: rtl/gray_run_ctrl_if.sv
// Button-in / counter-control-out bundle between the debouncer side and the Gray counter side.
// No handshake: btn_clean is a level; cnt_en, cnt_clr and wrap_done are single-cycle pulses, and running/state_o are levels, all valid every cycle.
interface gray_run_ctrl_if;

  logic       btn_clean;
  logic       cnt_en;
  logic       cnt_clr;
  logic       running;
  logic [1:0] state_o;
  logic       wrap_done;

  modport master (
    output btn_clean,
    input  cnt_en,
    input  cnt_clr,
    input  running,
    input  state_o,
    input  wrap_done
  );

  modport slave (
    input  btn_clean,
    output cnt_en,
    output cnt_clr,
    output running,
    output state_o,
    output wrap_done
  );

endinterface

// File: rtl/gray_run_ctrl_press_classifier.sv
// Turns the debounced button level into one-cycle short/long press events.
// A press that reaches the long threshold is marked fired so its release is not also a short press.
module press_classifier
  import gray_ctrl_pkg::*;
#(
  parameter int unsigned LONG_CYC = DEF_LONG_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_short_evt,
  output logic o_long_evt
);

  localparam int unsigned HW = $clog2(LONG_CYC);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC - 1);

  logic          r_btn_prev;
  logic [HW-1:0] r_hold_cnt;
  logic          r_long_fired;
  logic          w_long_evt;
  logic          w_short_evt;

  assign w_long_evt  = i_btn && (r_hold_cnt == HOLD_MAX) && !r_long_fired;
  assign w_short_evt = !i_btn && r_btn_prev && !r_long_fired;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_prev   <= 1'b0;
      r_hold_cnt   <= '0;
      r_long_fired <= 1'b0;
    end else begin
      r_btn_prev <= i_btn;
      if (!i_btn) begin
        r_hold_cnt   <= '0;
        r_long_fired <= 1'b0;
      end else begin
        if (r_hold_cnt != HOLD_MAX) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
        if (w_long_evt) begin
          r_long_fired <= 1'b1;
        end
      end
    end
  end

  assign o_short_evt = w_short_evt;
  assign o_long_evt  = w_long_evt;

endmodule

// File: rtl/gray_run_ctrl.sv
// Run/pause/clear sequencer driving the Gray counter's enable and clear from a prescaler and press events.
// Define GRAY_WRAP_STOP_EN to pause automatically after each full 2^N-step Gray cycle.
module gray_run_ctrl
  import gray_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD   = DEF_PERIOD,
  parameter int unsigned LONG_CYC = DEF_LONG_CYC,
  parameter int unsigned N        = 8
) (
  input  logic            clk,
  input  logic            rst,
  gray_run_ctrl_if.slave  ctrl
);

  localparam int unsigned PW = $clog2(PERIOD);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PERIOD - 1);

  state_e        r_state;
  state_e        w_next;
  logic [PW-1:0] r_presc;
  logic          w_short_evt;
  logic          w_long_evt;
  logic          w_cnt_en;
  logic          w_wrap_hit;

  press_classifier #(
    .LONG_CYC (LONG_CYC)
  ) u_press (
    .clk         (clk),
    .rst         (rst),
    .i_btn       (ctrl.btn_clean),
    .o_short_evt (w_short_evt),
    .o_long_evt  (w_long_evt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Long press wins over everything; CLEAR lasts exactly one cycle
  always_comb begin
    w_next   = r_state;
    w_cnt_en = (r_state == S_RUN) && (r_presc == PRESC_MAX);
    case (r_state)
      S_IDLE:  if (w_short_evt) w_next = S_RUN;
      S_RUN:   if (w_short_evt || w_wrap_hit) w_next = S_PAUSE;
      S_PAUSE: if (w_short_evt) w_next = S_RUN;
      S_CLEAR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_long_evt) begin
      w_next = S_CLEAR;
    end
  end

  // Phase survives PAUSE so resuming does not restart the current period
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else begin
      case (r_state)
        S_RUN:   r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
        S_PAUSE: r_presc <= r_presc;
        default: r_presc <= '0;
      endcase
    end
  end

`ifdef GRAY_WRAP_STOP_EN
  logic [N-1:0] r_ev_cnt;
  logic         r_wrap_done;

  assign w_wrap_hit = w_cnt_en && (r_ev_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ev_cnt    <= '0;
      r_wrap_done <= 1'b0;
    end else begin
      r_wrap_done <= w_wrap_hit && !w_long_evt;
      if ((r_state == S_IDLE) || (r_state == S_CLEAR)) begin
        r_ev_cnt <= '0;
      end else if (w_cnt_en) begin
        r_ev_cnt <= r_ev_cnt + 1'b1;
      end
    end
  end

  assign ctrl.wrap_done = r_wrap_done;
`else
  // N only sizes the event counter; this all-zero bus keeps it referenced
  logic [N-1:0] w_no_ev;

  assign w_no_ev        = '0;
  assign w_wrap_hit     = 1'b0;
  assign ctrl.wrap_done = |w_no_ev;
`endif

  assign ctrl.cnt_en  = w_cnt_en;
  assign ctrl.cnt_clr = (r_state == S_CLEAR);
  assign ctrl.running = (r_state == S_RUN);
  assign ctrl.state_o = r_state;

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Self-checking bench for gray_run_ctrl with PERIOD=4, LONG_CYC=10, N=2.
// Every cycle's outputs are predicted by a behavioural model and checked from an expected queue.
module tb_gray_run_ctrl;

  localparam int T_PERIOD = 4;
  localparam int T_LONG   = 10;
  localparam int T_N      = 2;

  logic clk;
  logic rst;

  gray_run_ctrl_if bus_if ();

  gray_run_ctrl #(
    .PERIOD   (T_PERIOD),
    .LONG_CYC (T_LONG),
    .N        (T_N)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // packed outputs: [5] wrap_done, [4:3] state_o, [2] running, [1] cnt_clr, [0] cnt_en
  logic [5:0] exp_q[$];
  logic [5:0] obs;
  logic [5:0] m_exp;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state = 0;
  int m_presc = 0;
  int m_hold  = 0;
  int m_prev  = 0;
  int m_fired = 0;
  int m_ev    = 0;
  int m_wrap  = 0;

  task automatic model_step(input logic b, input logic r);
    bit lng, sht, en, hit;
    int nxt;
    if (r) begin
      m_state = 0; m_presc = 0; m_hold = 0; m_prev = 0;
      m_fired = 0; m_ev = 0; m_wrap = 0;
    end else begin
      en  = (m_state == 1) && (m_presc == T_PERIOD - 1);
      lng = b && (m_fired == 0) && (m_hold == T_LONG - 1);
      sht = !b && (m_prev == 1) && (m_fired == 0);
      hit = 1'b0;
`ifdef GRAY_WRAP_STOP_EN
      hit = en && (m_ev == (1 << T_N) - 1);
      if (m_state == 0 || m_state == 3) m_ev = 0;
      else if (en) m_ev = (m_ev + 1) % (1 << T_N);
`endif
      m_wrap = (hit && !lng) ? 1 : 0;
      nxt = m_state;
      if (lng) nxt = 3;
      else if (m_state == 3) nxt = 0;
      else if (m_state == 0 && sht) nxt = 1;
      else if (m_state == 1 && (sht || hit)) nxt = 2;
      else if (m_state == 2 && sht) nxt = 1;
      if (m_state == 1) m_presc = (m_presc + 1) % T_PERIOD;
      else if (m_state != 2) m_presc = 0;
      m_state = nxt;
      if (b) begin
        if (lng) m_fired = 1;
        if (m_hold < T_LONG - 1) m_hold++;
      end else begin
        m_hold = 0;
        m_fired = 0;
      end
      m_prev = b ? 1 : 0;
    end
    m_exp = {m_wrap[0], 2'(m_state), (m_state == 1), (m_state == 3),
             (m_state == 1) && (m_presc == T_PERIOD - 1)};
  endtask

  // ---------------- driver ----------------
  // Samples the outputs of the current cycle, then drives this cycle's inputs.
  task automatic drive(input logic b, input logic r);
    @(negedge clk);
    obs = {bus_if.wrap_done, bus_if.state_o, bus_if.running, bus_if.cnt_clr, bus_if.cnt_en};
    if (exp_q.size() > 0) check_eq($sformatf("cyc%0d", cyc_n), obs, exp_q.pop_front());
    bus_if.btn_clean = b;
    rst = r;
    cyc_n++;
    model_step(b, r);
    exp_q.push_back(m_exp);
  endtask

  task automatic press_short();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  // Counts cycles (first one included) until cnt_en is seen; 99 if it never comes
  task automatic count_to_en(output int k);
    bit found;
    found = 1'b0;
    k = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, 1'b0);
      k++;
      if (obs[0]) found = 1'b1;
    end
    if (!found) k = 99;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int seen;
    int nclr;
    int clr_idx;
    int len;
    int gap;
    bus_if.btn_clean = 1'b0;
    rst = 1'b1;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);

    // idle with button low: nothing ever fires
    seen = 0;
    repeat (50) begin
      drive(1'b0, 1'b0);
      seen = seen | int'(obs[2:0]);
    end
    check_eq("idle_quiet", seen, 0);
    check_eq("idle_state", obs[4:3], 0);

    // 3-cycle press starts RUN; enables every PERIOD cycles
    repeat (3) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    count_to_en(k);
    check_eq("first_en", k, 4);
    check_eq("run_state", obs[4:3], 1);
    count_to_en(k);
    check_eq("second_en", k, 4);
    count_to_en(k);
    check_eq("third_en", k, 4);

    // release lands when presc=1 -> PAUSE, phase kept
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    seen = 0;
    repeat (3) begin
      drive(1'b0, 1'b0);
      seen = seen | int'(obs[0]);
    end
    check_eq("pause_state", obs[4:3], 2);
    check_eq("pause_no_en", seen, 0);
    press_short();
    count_to_en(k);
    check_eq("resume_phase", k, 2);

    // 14-cycle hold: one CLEAR after the 10th high cycle, then IDLE
    nclr = 0;
    clr_idx = 0;
    for (int i = 1; i <= 14; i++) begin
      drive(1'b1, 1'b0);
      if (obs[1]) begin
        nclr++;
        clr_idx = i;
      end
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0);
      if (obs[1]) nclr++;
    end
    check_eq("long_clr_cycle", clr_idx, 11);
    check_eq("long_clr_count", nclr, 1);
    check_eq("long_no_short", obs[4:3], 0);

    // reset mid-RUN at presc=2 with the button held through it
    press_short();
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    k = 99;
    for (int i = 1; i <= 20 && k == 99; i++) begin
      drive(1'b1, 1'b0);
      if (i == 1) begin
        check_eq("rst_state", obs[4:3], 0);
        check_eq("rst_en", obs[0], 0);
      end
      if (obs[4:3] == 2'd3) k = i;
    end
    check_eq("rst_fresh_long", k, 11);
    repeat (4) drive(1'b0, 1'b0);

`ifdef GRAY_WRAP_STOP_EN
    // wrap-stop: pause after 2^N enables, resume counts a fresh cycle
    press_short();
    for (int j = 0; j < 4; j++) count_to_en(k);
    drive(1'b0, 1'b0);
    check_eq("wrap_state", obs[4:3], 2);
    check_eq("wrap_done", obs[5], 1);
    drive(1'b0, 1'b0);
    check_eq("wrap_done_1cyc", obs[5], 0);
    press_short();
    for (int j = 0; j < 3; j++) count_to_en(k);
    drive(1'b0, 1'b0);
    check_eq("wrap_restart_run", obs[4:3], 1);
    count_to_en(k);
    drive(1'b0, 1'b0);
    check_eq("wrap_again", obs[4:3], 2);
    repeat (2) drive(1'b0, 1'b0);
`endif

    // random presses of mixed lengths, occasional reset
    repeat (60) begin
      len = $urandom_range(1, 14);
      gap = $urandom_range(1, 9);
      repeat (len) drive(1'b1, 1'b0);
      repeat (gap) drive(1'b0, 1'b0);
      if ($urandom_range(0, 15) == 0) drive(1'b0, 1'b1);
    end

    drive(1'b0, 1'b0);
    @(negedge clk);
    obs = {bus_if.wrap_done, bus_if.state_o, bus_if.running, bus_if.cnt_clr, bus_if.cnt_en};
    check_eq("final", obs, exp_q.pop_front());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
